// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared FSM state type and operand-forward select encodings for the hazard controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_hazard_ctrl_pkg;

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_DWAIT = 1'b1
   } state_t;

   // Operand source select driven to the ID-stage bypass muxes
   localparam logic [2:0] SEL_REG     = 3'b000;
   localparam logic [2:0] SEL_EXE_ALU = 3'b001;
   localparam logic [2:0] SEL_MEM_ALU = 3'b010;
   localparam logic [2:0] SEL_MEM_DIN = 3'b011;
   localparam logic [2:0] SEL_WB      = 3'b100;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// One operand's bypass priority compare: youngest matching producer wins (EXE, MEM, WB).
// Latency: purely combinational.
// Backpressure: none; the select is recomputed every cycle from the stage tags.
module fwd_select
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int FWD_WB = 1
) (
   input  logic              i_used,
   input  logic [REG_AW-1:0] i_addr,
   input  logic              i_wen_exe,
   input  logic              i_ren_exe,
   input  logic [REG_AW-1:0] i_addr_exe,
   input  logic              i_wen_mem,
   input  logic              i_ren_mem,
   input  logic [REG_AW-1:0] i_addr_mem,
   input  logic              i_wen_wb,
   input  logic [REG_AW-1:0] i_addr_wb,
   output logic [2:0]        o_sel
);

   logic w_hit_exe;
   logic w_hit_mem;
   logic w_hit_wb;

   // A load in EXE has no data yet, so it never bypasses from EXE
   assign w_hit_exe = i_used && i_wen_exe && !i_ren_exe &&
                      (i_addr_exe != '0) && (i_addr_exe == i_addr);
   assign w_hit_mem = i_used && i_wen_mem && (i_addr_mem != '0) && (i_addr_mem == i_addr);
   assign w_hit_wb  = i_used && (FWD_WB != 0) && i_wen_wb &&
                      (i_addr_wb != '0) && (i_addr_wb == i_addr);

   // Priority select: nearest stage holds the newest value of the register
   always_comb begin
      o_sel = SEL_REG;
      if (w_hit_exe) begin
         o_sel = SEL_EXE_ALU;
      end else if (w_hit_mem) begin
         o_sel = i_ren_mem ? SEL_MEM_DIN : SEL_MEM_ALU;
      end else if (w_hit_wb) begin
         o_sel = SEL_WB;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline with multi-cycle memory waits.
// Latency: stage controls and forward selects are combinational; state/counters update per clock.
// Backpressure: a pending data access freezes every stage until ack or timeout; fetch wait stalls IF/ID.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int REG_AW      = 5,
   parameter int DELAY_SLOT  = 0,
   parameter int FWD_WB      = 1,
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_id_valid,
   input  logic              i_rs_used,
   input  logic              i_rt_used,
   input  logic [REG_AW-1:0] i_addr_rs,
   input  logic [REG_AW-1:0] i_addr_rt,
   input  logic              i_redirect,
   input  logic              i_wb_wen_exe,
   input  logic              i_mem_ren_exe,
   input  logic [REG_AW-1:0] i_regw_addr_exe,
   input  logic              i_wb_wen_mem,
   input  logic              i_mem_ren_mem,
   input  logic [REG_AW-1:0] i_regw_addr_mem,
   input  logic              i_wb_wen_wb,
   input  logic [REG_AW-1:0] i_regw_addr_wb,
   input  logic              i_inst_req,
   input  logic              i_inst_ack,
   input  logic              i_mem_req,
   input  logic              i_mem_ack,
   output logic              o_if_en,
   output logic              o_id_en,
   output logic              o_exe_en,
   output logic              o_mem_en,
   output logic              o_wb_en,
   output logic              o_if_rst,
   output logic              o_id_rst,
   output logic              o_exe_rst,
   output logic              o_mem_rst,
   output logic              o_wb_rst,
   output logic [2:0]        o_fwd_a,
   output logic [2:0]        o_fwd_b,
   output logic              o_reg_stall,
   output logic              o_mem_err,
   output logic [CNT_W-1:0]  o_stall_cycles
);

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [WAIT_W-1:0]   r_wait_cnt;
   logic [WAIT_W-1:0]   w_wait_nxt;
   logic                r_mem_err;
   logic                w_mem_err_nxt;
   logic [CNT_W-1:0]    r_stall_cnt;
   logic                w_freeze;
   logic                w_timeout;
   logic                w_load_use;
   logic                w_redirect;
   logic                w_inst_wait;
   logic [2:0]          w_fwd_a;
   logic [2:0]          w_fwd_b;

   assign w_timeout   = (MEM_TIMEOUT != 0) && (r_wait_cnt == WAIT_LAST);
   assign w_redirect  = i_id_valid && i_redirect;
   assign w_inst_wait = i_inst_req && !i_inst_ack;
   assign w_load_use  = i_id_valid && i_wb_wen_exe && i_mem_ren_exe && (i_regw_addr_exe != '0) &&
                        ((i_rs_used && (i_addr_rs == i_regw_addr_exe)) ||
                         (i_rt_used && (i_addr_rt == i_regw_addr_exe)));

   fwd_select #(.REG_AW(REG_AW), .FWD_WB(FWD_WB)) u_fwd_a (
      .i_used     (i_rs_used),
      .i_addr     (i_addr_rs),
      .i_wen_exe  (i_wb_wen_exe),
      .i_ren_exe  (i_mem_ren_exe),
      .i_addr_exe (i_regw_addr_exe),
      .i_wen_mem  (i_wb_wen_mem),
      .i_ren_mem  (i_mem_ren_mem),
      .i_addr_mem (i_regw_addr_mem),
      .i_wen_wb   (i_wb_wen_wb),
      .i_addr_wb  (i_regw_addr_wb),
      .o_sel      (w_fwd_a)
   );

   fwd_select #(.REG_AW(REG_AW), .FWD_WB(FWD_WB)) u_fwd_b (
      .i_used     (i_rt_used),
      .i_addr     (i_addr_rt),
      .i_wen_exe  (i_wb_wen_exe),
      .i_ren_exe  (i_mem_ren_exe),
      .i_addr_exe (i_regw_addr_exe),
      .i_wen_mem  (i_wb_wen_mem),
      .i_ren_mem  (i_mem_ren_mem),
      .i_addr_mem (i_regw_addr_mem),
      .i_wen_wb   (i_wb_wen_wb),
      .i_addr_wb  (i_regw_addr_wb),
      .o_sel      (w_fwd_b)
   );

   // Next-state and stage controls: reset, then freeze, then redirect > load-use > fetch wait
   always_comb begin
      w_state_nxt   = r_state;
      w_wait_nxt    = r_wait_cnt;
      w_mem_err_nxt = r_mem_err;
      w_freeze      = 1'b0;
      o_if_en       = 1'b1;
      o_id_en       = 1'b1;
      o_exe_en      = 1'b1;
      o_mem_en      = 1'b1;
      o_wb_en       = 1'b1;
      o_if_rst      = 1'b0;
      o_id_rst      = 1'b0;
      o_exe_rst     = 1'b0;
      o_mem_rst     = 1'b0;
      o_wb_rst      = 1'b0;
      o_reg_stall   = 1'b0;

      case (r_state)
         ST_RUN: begin
            if (i_mem_req && !i_mem_ack) begin
               w_freeze    = 1'b1;
               w_state_nxt = ST_DWAIT;
               w_wait_nxt  = '0;
            end
         end
         ST_DWAIT: begin
            if (i_mem_ack) begin
               w_state_nxt = ST_RUN;
               w_wait_nxt  = '0;
            end else if (w_timeout) begin
               w_state_nxt   = ST_RUN;
               w_wait_nxt    = '0;
               w_mem_err_nxt = 1'b1;
            end else begin
               w_freeze   = 1'b1;
               w_wait_nxt = r_wait_cnt + WAIT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_RUN;
         end
      endcase

      if (i_rst) begin
         {o_if_en, o_id_en, o_exe_en, o_mem_en, o_wb_en}      = 5'b00000;
         {o_if_rst, o_id_rst, o_exe_rst, o_mem_rst, o_wb_rst} = 5'b11111;
      end else if (w_freeze) begin
         // Holding wb_en low keeps the register write from repeating while frozen
         {o_if_en, o_id_en, o_exe_en, o_mem_en, o_wb_en} = 5'b00000;
      end else if (w_redirect) begin
         // IF loads the target; any outstanding fetch is simply dropped
         if (DELAY_SLOT == 0) begin
            o_id_rst = 1'b1;
         end
      end else if (w_load_use) begin
         o_reg_stall = 1'b1;
         o_if_en     = 1'b0;
         o_id_en     = 1'b0;
         o_exe_rst   = 1'b1;
      end else if (w_inst_wait) begin
         o_if_en   = 1'b0;
         o_id_en   = 1'b0;
         o_exe_rst = 1'b1;
      end
   end

   assign o_fwd_a        = i_rst ? SEL_REG : w_fwd_a;
   assign o_fwd_b        = i_rst ? SEL_REG : w_fwd_b;
   assign o_mem_err      = r_mem_err && !i_rst;
   assign o_stall_cycles = i_rst ? '0 : r_stall_cnt;

   // State, wait counter, sticky error and saturating stall counter
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_RUN;
         r_wait_cnt  <= '0;
         r_mem_err   <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         r_mem_err  <= w_mem_err_nxt;
         if (!o_if_en && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for the hazard controller: reset, load-use, forwarding, waits, redirects.
// Latency: checks combinational controls mid-cycle and registered state one clock later.
// Backpressure: memory acks are driven by hand to shape freeze lengths.
module tb_pipe_hazard_ctrl;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_id_valid, i_rs_used, i_rt_used, i_redirect;
   logic [4:0]  i_addr_rs, i_addr_rt;
   logic        i_wb_wen_exe, i_mem_ren_exe, i_wb_wen_mem, i_mem_ren_mem, i_wb_wen_wb;
   logic [4:0]  i_regw_addr_exe, i_regw_addr_mem, i_regw_addr_wb;
   logic        i_inst_req, i_inst_ack, i_mem_req, i_mem_ack;

   logic        o_if_en, o_id_en, o_exe_en, o_mem_en, o_wb_en;
   logic        o_if_rst, o_id_rst, o_exe_rst, o_mem_rst, o_wb_rst;
   logic [2:0]  o_fwd_a, o_fwd_b;
   logic        o_reg_stall, o_mem_err;
   logic [31:0] o_stall_cycles;

   logic        ds_if_en, ds_id_en, ds_exe_en, ds_mem_en, ds_wb_en;
   logic        ds_if_rst, ds_id_rst, ds_exe_rst, ds_mem_rst, ds_wb_rst;
   logic [2:0]  ds_fwd_a, ds_fwd_b;
   logic        ds_reg_stall, ds_mem_err;
   logic [31:0] ds_stall_cycles;

   logic [4:0]  w_en, w_rst;
   assign w_en  = {o_if_en, o_id_en, o_exe_en, o_mem_en, o_wb_en};
   assign w_rst = {o_if_rst, o_id_rst, o_exe_rst, o_mem_rst, o_wb_rst};

   int n_checks = 0;
   int n_fail   = 0;

   always #5 i_clk = ~i_clk;

   pipe_hazard_ctrl #(.REG_AW(5), .DELAY_SLOT(0), .FWD_WB(1), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_id_valid(i_id_valid), .i_rs_used(i_rs_used),
      .i_rt_used(i_rt_used), .i_addr_rs(i_addr_rs), .i_addr_rt(i_addr_rt), .i_redirect(i_redirect),
      .i_wb_wen_exe(i_wb_wen_exe), .i_mem_ren_exe(i_mem_ren_exe), .i_regw_addr_exe(i_regw_addr_exe),
      .i_wb_wen_mem(i_wb_wen_mem), .i_mem_ren_mem(i_mem_ren_mem), .i_regw_addr_mem(i_regw_addr_mem),
      .i_wb_wen_wb(i_wb_wen_wb), .i_regw_addr_wb(i_regw_addr_wb), .i_inst_req(i_inst_req),
      .i_inst_ack(i_inst_ack), .i_mem_req(i_mem_req), .i_mem_ack(i_mem_ack),
      .o_if_en(o_if_en), .o_id_en(o_id_en), .o_exe_en(o_exe_en), .o_mem_en(o_mem_en), .o_wb_en(o_wb_en),
      .o_if_rst(o_if_rst), .o_id_rst(o_id_rst), .o_exe_rst(o_exe_rst), .o_mem_rst(o_mem_rst),
      .o_wb_rst(o_wb_rst), .o_fwd_a(o_fwd_a), .o_fwd_b(o_fwd_b), .o_reg_stall(o_reg_stall),
      .o_mem_err(o_mem_err), .o_stall_cycles(o_stall_cycles)
   );

   pipe_hazard_ctrl #(.REG_AW(5), .DELAY_SLOT(1), .FWD_WB(1), .MEM_TIMEOUT(4), .CNT_W(32)) dut_ds (
      .i_clk(i_clk), .i_rst(i_rst), .i_id_valid(i_id_valid), .i_rs_used(i_rs_used),
      .i_rt_used(i_rt_used), .i_addr_rs(i_addr_rs), .i_addr_rt(i_addr_rt), .i_redirect(i_redirect),
      .i_wb_wen_exe(i_wb_wen_exe), .i_mem_ren_exe(i_mem_ren_exe), .i_regw_addr_exe(i_regw_addr_exe),
      .i_wb_wen_mem(i_wb_wen_mem), .i_mem_ren_mem(i_mem_ren_mem), .i_regw_addr_mem(i_regw_addr_mem),
      .i_wb_wen_wb(i_wb_wen_wb), .i_regw_addr_wb(i_regw_addr_wb), .i_inst_req(i_inst_req),
      .i_inst_ack(i_inst_ack), .i_mem_req(i_mem_req), .i_mem_ack(i_mem_ack),
      .o_if_en(ds_if_en), .o_id_en(ds_id_en), .o_exe_en(ds_exe_en), .o_mem_en(ds_mem_en),
      .o_wb_en(ds_wb_en), .o_if_rst(ds_if_rst), .o_id_rst(ds_id_rst), .o_exe_rst(ds_exe_rst),
      .o_mem_rst(ds_mem_rst), .o_wb_rst(ds_wb_rst), .o_fwd_a(ds_fwd_a), .o_fwd_b(ds_fwd_b),
      .o_reg_stall(ds_reg_stall), .o_mem_err(ds_mem_err), .o_stall_cycles(ds_stall_cycles)
   );

   task automatic clear_in();
      i_id_valid = 0; i_rs_used = 0; i_rt_used = 0; i_redirect = 0;
      i_addr_rs = 0; i_addr_rt = 0;
      i_wb_wen_exe = 0; i_mem_ren_exe = 0; i_regw_addr_exe = 0;
      i_wb_wen_mem = 0; i_mem_ren_mem = 0; i_regw_addr_mem = 0;
      i_wb_wen_wb = 0; i_regw_addr_wb = 0;
      i_inst_req = 0; i_inst_ack = 0; i_mem_req = 0; i_mem_ack = 0;
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      i_rst = 1; i_mem_req = 1; i_id_valid = 1; i_rs_used = 1; i_addr_rs = 1;
      i_wb_wen_exe = 1; i_mem_ren_exe = 1; i_regw_addr_exe = 1;
      #1;
      if (w_rst !== 5'b11111) begin $display("FAIL rst_vec: got %b want %b", w_rst, 5'b11111); n_fail++; end
      n_checks++;
      if (w_en !== 5'b00000) begin $display("FAIL rst_en: got %b want %b", w_en, 5'b00000); n_fail++; end
      n_checks++;
      if (o_reg_stall !== 1'b0) begin $display("FAIL rst_stall: got %b want 0", o_reg_stall); n_fail++; end
      n_checks++;
      if (o_fwd_a !== 3'b000) begin $display("FAIL rst_fwd: got %b want 000", o_fwd_a); n_fail++; end
      n_checks++;
      if (o_mem_err !== 1'b0 || o_stall_cycles !== 32'd0) begin
         $display("FAIL rst_regs: got err=%b cnt=%0d want 0/0", o_mem_err, o_stall_cycles); n_fail++;
      end
      n_checks++;
      tick(); tick();
      clear_in(); i_rst = 0;
      #1;
      if (w_en !== 5'b11111 || w_rst !== 5'b00000) begin
         $display("FAIL post_rst_run: got en=%b rst=%b want 11111/00000", w_en, w_rst); n_fail++;
      end
      n_checks++;
      tick();
      if (o_stall_cycles !== 32'd0) begin $display("FAIL post_rst_cnt: got %0d want 0", o_stall_cycles); n_fail++; end
      n_checks++;
   endtask

   task automatic test_load_use();
      logic [31:0] s0;
      clear_in(); tick();
      i_id_valid = 1; i_rs_used = 1; i_addr_rs = 1; i_rt_used = 1; i_addr_rt = 7;
      i_wb_wen_exe = 1; i_mem_ren_exe = 1; i_regw_addr_exe = 1;
      #1;
      s0 = o_stall_cycles;
      if (o_reg_stall !== 1'b1) begin $display("FAIL lu_stall: got %b want 1", o_reg_stall); n_fail++; end
      n_checks++;
      if (w_en !== 5'b00111 || w_rst !== 5'b00100) begin
         $display("FAIL lu_ctrl: got en=%b rst=%b want 00111/00100", w_en, w_rst); n_fail++;
      end
      n_checks++;
      tick();
      i_wb_wen_exe = 0; i_mem_ren_exe = 0; i_regw_addr_exe = 0;
      i_wb_wen_mem = 1; i_mem_ren_mem = 1; i_regw_addr_mem = 1;
      #1;
      if (o_reg_stall !== 1'b0 || w_en !== 5'b11111) begin
         $display("FAIL lu_one_cycle: got stall=%b en=%b want 0/11111", o_reg_stall, w_en); n_fail++;
      end
      n_checks++;
      if (o_fwd_a !== 3'b011 || o_fwd_b !== 3'b000) begin
         $display("FAIL lu_fwd: got a=%b b=%b want 011/000", o_fwd_a, o_fwd_b); n_fail++;
      end
      n_checks++;
      if (o_stall_cycles !== s0 + 32'd1) begin
         $display("FAIL lu_cnt: got %0d want %0d", o_stall_cycles, s0 + 32'd1); n_fail++;
      end
      n_checks++;
      // A load into $0 is never a hazard
      clear_in(); i_id_valid = 1; i_rs_used = 1; i_wb_wen_exe = 1; i_mem_ren_exe = 1;
      #1;
      if (o_reg_stall !== 1'b0) begin $display("FAIL lu_r0: got %b want 0", o_reg_stall); n_fail++; end
      n_checks++;
   endtask

   task automatic test_forward();
      clear_in(); tick();
      i_id_valid = 1; i_rs_used = 1; i_addr_rs = 5; i_rt_used = 1; i_addr_rt = 2;
      i_wb_wen_exe = 1; i_regw_addr_exe = 2;
      #1;
      if (o_fwd_b !== 3'b001 || o_fwd_a !== 3'b000 || o_reg_stall !== 1'b0) begin
         $display("FAIL fwd_exe: got a=%b b=%b stall=%b want 000/001/0", o_fwd_a, o_fwd_b, o_reg_stall); n_fail++;
      end
      n_checks++;
      i_regw_addr_exe = 0; i_addr_rt = 0;
      #1;
      if (o_fwd_b !== 3'b000) begin $display("FAIL fwd_r0: got %b want 000", o_fwd_b); n_fail++; end
      n_checks++;
      i_addr_rt = 2; i_regw_addr_exe = 2; i_wb_wen_mem = 1; i_regw_addr_mem = 2;
      i_wb_wen_wb = 1; i_regw_addr_wb = 5;
      #1;
      if (o_fwd_b !== 3'b001 || o_fwd_a !== 3'b100) begin
         $display("FAIL fwd_prio_wb: got a=%b b=%b want 100/001", o_fwd_a, o_fwd_b); n_fail++;
      end
      n_checks++;
      i_wb_wen_exe = 0;
      #1;
      if (o_fwd_b !== 3'b010) begin $display("FAIL fwd_mem_alu: got %b want 010", o_fwd_b); n_fail++; end
      n_checks++;
      i_rt_used = 0; i_rs_used = 0;
      #1;
      if (o_fwd_b !== 3'b000 || o_fwd_a !== 3'b000) begin
         $display("FAIL fwd_unused: got a=%b b=%b want 000/000", o_fwd_a, o_fwd_b); n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_inst_wait();
      clear_in(); tick();
      i_inst_req = 1;
      #1;
      if (w_en !== 5'b00111 || w_rst !== 5'b00100 || o_reg_stall !== 1'b0) begin
         $display("FAIL iwait: got en=%b rst=%b stall=%b want 00111/00100/0", w_en, w_rst, o_reg_stall); n_fail++;
      end
      n_checks++;
      i_inst_ack = 1;
      #1;
      if (w_en !== 5'b11111) begin $display("FAIL iwait_ack: got %b want 11111", w_en); n_fail++; end
      n_checks++;
   endtask

   task automatic test_redirect();
      clear_in(); tick();
      i_id_valid = 1; i_redirect = 1; i_inst_req = 1;
      #1;
      if (o_id_rst !== 1'b1 || o_if_en !== 1'b1 || o_exe_rst !== 1'b0) begin
         $display("FAIL redir_flush: got id_rst=%b if_en=%b exe_rst=%b want 1/1/0", o_id_rst, o_if_en, o_exe_rst);
         n_fail++;
      end
      n_checks++;
      if (ds_id_rst !== 1'b0 || ds_id_en !== 1'b1 || ds_if_en !== 1'b1) begin
         $display("FAIL redir_slot: got id_rst=%b id_en=%b if_en=%b want 0/1/1", ds_id_rst, ds_id_en, ds_if_en);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_priority();
      clear_in(); tick();
      i_id_valid = 1; i_redirect = 1; i_rs_used = 1; i_addr_rs = 3;
      i_wb_wen_exe = 1; i_mem_ren_exe = 1; i_regw_addr_exe = 3;
      #1;
      if (o_reg_stall !== 1'b0 || o_id_rst !== 1'b1 || o_if_en !== 1'b1 || o_exe_rst !== 1'b0) begin
         $display("FAIL redir_over_lu: got stall=%b id_rst=%b if_en=%b exe_rst=%b want 0/1/1/0",
                  o_reg_stall, o_id_rst, o_if_en, o_exe_rst);
         n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_mem_wait();
      logic [31:0] s0;
      clear_in(); tick();
      s0 = o_stall_cycles;
      i_mem_req = 1;
      #1;
      if (w_en !== 5'b00000 || w_rst !== 5'b00000) begin
         $display("FAIL mw_first: got en=%b rst=%b want 00000/00000", w_en, w_rst); n_fail++;
      end
      n_checks++;
      tick();
      i_id_valid = 1; i_redirect = 1;
      #1;
      if (w_en !== 5'b00000 || o_id_rst !== 1'b0) begin
         $display("FAIL mw_redir_held: got en=%b id_rst=%b want 00000/0", w_en, o_id_rst); n_fail++;
      end
      n_checks++;
      tick();
      if (o_wb_en !== 1'b0) begin $display("FAIL mw_wb_en: got %b want 0", o_wb_en); n_fail++; end
      n_checks++;
      tick();
      i_mem_ack = 1;
      #1;
      if (w_en !== 5'b11111 || o_id_rst !== 1'b1) begin
         $display("FAIL mw_release: got en=%b id_rst=%b want 11111/1", w_en, o_id_rst); n_fail++;
      end
      n_checks++;
      tick();
      clear_in();
      #1;
      if (o_stall_cycles !== s0 + 32'd3) begin
         $display("FAIL mw_cnt: got %0d want %0d", o_stall_cycles, s0 + 32'd3); n_fail++;
      end
      n_checks++;
      if (w_en !== 5'b11111 || o_mem_err !== 1'b0) begin
         $display("FAIL mw_back_run: got en=%b err=%b want 11111/0", w_en, o_mem_err); n_fail++;
      end
      n_checks++;
   endtask

   task automatic test_timeout();
      logic [31:0] s0;
      clear_in(); tick();
      s0 = o_stall_cycles;
      i_mem_req = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (w_en !== 5'b00000) begin $display("FAIL to_frozen%0d: got %b want 00000", i, w_en); n_fail++; end
         n_checks++;
         tick();
      end
      #1;
      if (w_en !== 5'b11111 || o_mem_err !== 1'b0) begin
         $display("FAIL to_release: got en=%b err=%b want 11111/0", w_en, o_mem_err); n_fail++;
      end
      n_checks++;
      tick();
      i_mem_req = 0;
      #1;
      if (o_mem_err !== 1'b1) begin $display("FAIL to_err: got %b want 1", o_mem_err); n_fail++; end
      n_checks++;
      if (o_stall_cycles !== s0 + 32'd4) begin
         $display("FAIL to_cnt: got %0d want %0d", o_stall_cycles, s0 + 32'd4); n_fail++;
      end
      n_checks++;
      tick(); tick();
      if (o_mem_err !== 1'b1) begin $display("FAIL to_sticky: got %b want 1", o_mem_err); n_fail++; end
      n_checks++;
   endtask

   task automatic test_rst_mid_dwait();
      clear_in(); tick();
      i_mem_req = 1;
      tick(); tick();
      i_rst = 1;
      #1;
      if (w_rst !== 5'b11111 || o_mem_err !== 1'b0) begin
         $display("FAIL rd_rst: got rst=%b err=%b want 11111/0", w_rst, o_mem_err); n_fail++;
      end
      n_checks++;
      for (int i = 0; i < 5; i++) tick();
      i_rst = 0; i_mem_req = 0;
      #1;
      if (w_en !== 5'b11111) begin $display("FAIL rd_run: got en=%b want 11111", w_en); n_fail++; end
      n_checks++;
      tick();
      if (o_mem_err !== 1'b0 || o_stall_cycles !== 32'd0) begin
         $display("FAIL rd_regs: got err=%b cnt=%0d want 0/0", o_mem_err, o_stall_cycles); n_fail++;
      end
      n_checks++;
   endtask

   initial begin
      clear_in();
      i_rst = 1;
      tick();
      test_reset();
      test_load_use();
      test_forward();
      test_inst_wait();
      test_redirect();
      test_priority();
      test_mem_wait();
      test_timeout();
      test_rst_mid_dwait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
